// File: rtl/input_cond_pkg.sv
// -----------------------------------------------------------------------------
// input_cond_pkg
//   Shared types and helpers for the input conditioner.
//   - ic_state_e : per-channel press-tracking state (idle / pressed / held).
//   - cnt_width  : bits needed for a counter that must hold values 0..max.
// -----------------------------------------------------------------------------
package input_cond_pkg;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_PRESSED = 2'd1,
    IC_HELD    = 2'd2
  } ic_state_e;

  // Width of a counter that must represent every value from 0 up to max.
  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/input_cond_channel.sv
// -----------------------------------------------------------------------------
// input_cond_channel
//   One conditioned input: synchroniser chain, instant-response lockout
//   debounce, registered edge pulses and a long-press / auto-repeat tracker.
//
//   Ports
//     g_clk        : clock
//     g_nrst       : synchronous active-low reset
//     ena          : channel enable; when low, all state except the
//                    synchroniser freezes and every pulse is held at 0
//     sig_in       : raw asynchronous input
//     repeat_en    : allows repeat_pulse while long-pressed
//     sig_stable   : debounced level
//     rise_pulse   : one cycle, first cycle sig_stable shows a new 1
//     fall_pulse   : one cycle, first cycle sig_stable shows a new 0
//     long_press   : level, high while held past LONG_PRESS_CYCLES
//     repeat_pulse : one cycle on entering HELD, then every REPEAT_CYCLES
// -----------------------------------------------------------------------------
module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 20_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter int REPEAT_CYCLES     = 20_000_000
) (
  input  logic g_clk,
  input  logic g_nrst,
  input  logic ena,
  input  logic sig_in,
  input  logic repeat_en,
  output logic sig_stable,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int LOCK_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);
  localparam int REP_W  = cnt_width(REPEAT_CYCLES);

  localparam logic [LOCK_W-1:0] LOCK_ZERO = '0;
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1'b1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(DEBOUNCE_CYCLES);

  localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
  // The counter is cleared in the edge that enters PRESSED, so the hold
  // ends one count early to land long_press exactly LONG_PRESS_CYCLES later.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  localparam logic [REP_W-1:0]  REP_ZERO  = '0;
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1'b1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_d,   sync_q;
  logic                   stable_d, stable_q;
  logic [LOCK_W-1:0]      lock_d,   lock_q;
  logic                   rise_d,   rise_q;
  logic                   fall_d,   fall_q;
  ic_state_e              state_d,  state_q;
  logic [HOLD_W-1:0]      hold_d,   hold_q;
  logic [REP_W-1:0]       rep_d,    rep_q;
  logic                   long_d,   long_q;
  logic                   rpt_d,    rpt_q;

  logic                   sync_out_s;

  assign sync_out_s = sync_q[SYNC_STAGES-1];

  // Next-state logic: synchroniser shift, debounce, edge pulses and press FSM.
  always_comb begin
    // The synchroniser keeps sampling even while the channel is disabled.
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    stable_d = stable_q;
    lock_d   = lock_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    state_d  = state_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    long_d   = long_q;
    rpt_d    = 1'b0;

    if (ena) begin
      // Lockout debounce: the first differing sample is taken at once, then
      // the input is ignored until the lockout window has drained.
      if (lock_q == LOCK_ZERO) begin
        if (sync_out_s != stable_q) begin
          stable_d = sync_out_s;
          lock_d   = LOCK_LOAD;
          rise_d   = sync_out_s;
          fall_d   = ~sync_out_s;
        end else begin
          stable_d = stable_q;
        end
      end else begin
        lock_d = lock_q - LOCK_ONE;
      end

      // The FSM reacts to the debounce decision of this same edge so that
      // PRESSED/IDLE line up with the first cycle of the new stable level.
      case (state_q)
        IC_IDLE: begin
          if (rise_d) begin
            state_d = IC_PRESSED;
            hold_d  = HOLD_ZERO;
          end else begin
            state_d = IC_IDLE;
          end
        end
        IC_PRESSED: begin
          if (fall_d) begin
            state_d = IC_IDLE;
            long_d  = 1'b0;
          end else if (hold_q == HOLD_LAST) begin
            state_d = IC_HELD;
            long_d  = 1'b1;
            rep_d   = REP_ZERO;
            rpt_d   = repeat_en;
          end else begin
            hold_d  = hold_q + HOLD_ONE;
          end
        end
        IC_HELD: begin
          // A release wins over a due repeat so no pulse escapes with the fall.
          if (fall_d) begin
            state_d = IC_IDLE;
            long_d  = 1'b0;
          end else if (rep_q == REP_LAST) begin
            rep_d   = REP_ZERO;
            rpt_d   = repeat_en;
          end else begin
            rep_d   = rep_q + REP_ONE;
          end
        end
        default: begin
          state_d = IC_IDLE;
          long_d  = 1'b0;
        end
      endcase
    end else begin
      // Disabled: everything holds, pulses stay at their 0 defaults.
      stable_d = stable_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge g_clk) begin
    if (!g_nrst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      lock_q   <= LOCK_ZERO;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      state_q  <= IC_IDLE;
      hold_q   <= HOLD_ZERO;
      rep_q    <= REP_ZERO;
      long_q   <= 1'b0;
      rpt_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      lock_q   <= lock_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      rep_q    <= rep_d;
      long_q   <= long_d;
      rpt_q    <= rpt_d;
    end
  end

  assign sig_stable   = stable_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign long_press   = long_q;
  assign repeat_pulse = rpt_q;

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Multi-channel front end for raw board inputs. Each channel is an
//   independent input_cond_channel; this level only replicates them and
//   rejects illegal parameter sets at elaboration.
//
//   Ports (all vectors NUM_CHANNELS wide, bit i belongs to channel i)
//     g_clk        : single clock
//     g_nrst       : synchronous active-low reset
//     ena          : per-channel enable
//     sig_in       : raw asynchronous inputs
//     repeat_en    : per-channel auto-repeat enable
//     sig_stable   : debounced levels
//     rise_pulse   : accepted 0->1 transitions (one cycle)
//     fall_pulse   : accepted 1->0 transitions (one cycle)
//     long_press   : held past LONG_PRESS_CYCLES
//     repeat_pulse : auto-repeat pulses while long-pressed
// -----------------------------------------------------------------------------
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NUM_CHANNELS      = 8,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 20_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter int REPEAT_CYCLES     = 20_000_000
) (
  input  logic                    g_clk,
  input  logic                    g_nrst,
  input  logic [NUM_CHANNELS-1:0] ena,
  input  logic [NUM_CHANNELS-1:0] sig_in,
  input  logic [NUM_CHANNELS-1:0] repeat_en,
  output logic [NUM_CHANNELS-1:0] sig_stable,
  output logic [NUM_CHANNELS-1:0] rise_pulse,
  output logic [NUM_CHANNELS-1:0] fall_pulse,
  output logic [NUM_CHANNELS-1:0] long_press,
  output logic [NUM_CHANNELS-1:0] repeat_pulse
);

  // Parameter legality; only an illegal set elaborates these branches.
  if (NUM_CHANNELS < 1) begin : g_bad_channels
    $error("input_conditioner: NUM_CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("input_conditioner: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("input_conditioner: REPEAT_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    input_cond_channel #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_ch (
      .g_clk       (g_clk),
      .g_nrst      (g_nrst),
      .ena         (ena[i]),
      .sig_in      (sig_in[i]),
      .repeat_en   (repeat_en[i]),
      .sig_stable  (sig_stable[i]),
      .rise_pulse  (rise_pulse[i]),
      .fall_pulse  (fall_pulse[i]),
      .long_press  (long_press[i]),
      .repeat_pulse(repeat_pulse[i])
    );
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised, multi-channel front end for raw board inputs (pushbuttons, switches, external pins).
- Per channel, in order: N-stage synchroniser, instant-response lockout debounce, edge detection, and a long-press / auto-repeat state machine.
- Replaces the per-signal sync register plus debouncer instances at the top level with one block.
- Feeds clean levels and single-cycle event pulses to the timer/stopwatch control logic.

Parameters:
- NUM_CHANNELS, 8: number of independent input channels.
- SYNC_STAGES, 2: synchroniser flops per channel; must be ≥2.
- DEBOUNCE_CYCLES, 20_000: lockout cycles after each accepted transition (0.2 ms at 100 MHz); must be ≥1.
- LONG_PRESS_CYCLES, 100_000_000: cycles sig_stable must stay high before long_press asserts (1 s); must be > DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 20_000_000: period of repeat_pulse while long-pressed (0.2 s); must be ≥1.

Ports:
- g_clk, input, 1: single clock for everything.
- g_nrst, input, 1: reset, synchronous, active-low.
- ena, input, NUM_CHANNELS: per-channel enable.
- sig_in, input, NUM_CHANNELS: raw asynchronous inputs.
- repeat_en, input, NUM_CHANNELS: per-channel auto-repeat enable.
- sig_stable, output, NUM_CHANNELS: debounced level.
- rise_pulse, output, NUM_CHANNELS: 1-cycle pulse on each accepted 0→1 transition.
- fall_pulse, output, NUM_CHANNELS: 1-cycle pulse on each accepted 1→0 transition.
- long_press, output, NUM_CHANNELS: level, high while the channel is held past LONG_PRESS_CYCLES.
- repeat_pulse, output, NUM_CHANNELS: 1-cycle pulses during long press when repeat_en is set.

Behaviour:
- Reset (g_nrst=0 sampled on a g_clk edge): all sync flops, sig_stable, all pulses, long_press, repeat_pulse, lockout and hold counters go to 0; FSM goes to IDLE. Reset takes effect at that edge regardless of state.
- Sync: sig_in passes through SYNC_STAGES flops and always samples, even when ena=0. Call the last stage s.
- Debounce: when lockout=0 and s≠sig_stable, sig_stable takes s at the next edge and lockout loads DEBOUNCE_CYCLES. While lockout>0, s is ignored and lockout decrements once per enabled cycle. When lockout reaches 0 with s still different, the change is accepted immediately (same rule).
- Latency: a clean sig_in edge appears on sig_stable SYNC_STAGES+1 cycles later.
- Edges: rise_pulse / fall_pulse are registered and high exactly in the first cycle sig_stable shows its new value.
- FSM per channel: IDLE, PRESSED, HELD.
  - IDLE→PRESSED: when sig_stable rises; hold counter cleared.
  - PRESSED: hold counter increments each enabled cycle. When it reaches LONG_PRESS_CYCLES-1 → HELD; long_press=1 in the first HELD cycle, so long_press asserts exactly LONG_PRESS_CYCLES cycles after sig_stable rises.
  - HELD: one repeat_pulse on entry if repeat_en=1, then one every REPEAT_CYCLES cycles while held. repeat_en is sampled per pulse; toggling it gates future pulses only.
  - PRESSED or HELD→IDLE: in the same cycle sig_stable falls; long_press drops with fall_pulse.
- ena[i]=0: lockout, hold and repeat counters, sig_stable and FSM state freeze for that channel; all pulses for that channel are forced to 0; long_press holds its value.
- Reset release with sig_in already high: treated as a fresh press, so rise_pulse fires SYNC_STAGES+1 cycles after release.
- Counter widths: $clog2(max+1) of the relevant parameter; no wrap-around is reachable.
- Elaboration: a parameter-range violation raises $error.

Decomposition:
- Package input_cond_pkg:
  - enum ic_state_e {IC_IDLE, IC_PRESSED, IC_HELD};
  - function cnt_width(int max) returning $clog2(max+1).
- Sub-module input_cond_channel: sync chain, debounce, FSM and counters for one channel. Instantiated NUM_CHANNELS times via generate in input_conditioner.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=5, ena=all 1):
- Clean press: sig_in[0] rises before edge 0 → sig_stable[0]=1 and rise_pulse[0]=1 from edge 3; pulse lasts one cycle; other channels stay 0.
- Bounce: sig_in[1] toggles 1,0,1,0 on cycles 0–3, then stays 1 → exactly one rise_pulse; no fall_pulse; sig_stable[1] stays 1 throughout.
- Long press: sig_in[2] high 40 cycles with repeat_en[2]=1 → sig_stable rises at 3; long_press at 23; repeat_pulse at 23, 28, 33, 38. On release, fall_pulse and long_press=0 in the same cycle.
- No repeat: repeat_en[3]=0 with the same hold → long_press asserts at 23; repeat_pulse never asserts.
- Mid-hold reset: g_nrst=0 for one cycle in HELD with sig_in high → all outputs 0 next cycle. After release, rise_pulse fires again 3 cycles later and long_press returns 20 cycles after that.
- Enable freeze: ena[2]=0 for 7 cycles during PRESSED → long_press delayed to cycle 30; no pulses while ena is low.
